// File: rtl/trigger_timestamp_fifo.sv
// Trace-trigger capture FIFO: records {rule, timestamp} for each armed match cycle.
// Optional macro TRIGGER_TIMESTAMP_DELTA_EN stores cycles since the previous capture instead of the absolute counter.
module trigger_timestamp_fifo #(
    parameter int pNUM_RULES = 8,
    parameter int pTS_WIDTH  = 56,
    parameter int pDEPTH     = 16
) (
    input  logic                    trace_clk,
    input  logic                    reset_i,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [pNUM_RULES-1:0]   match,
    input  logic                    rd_en,
    output logic [63:0]             rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(pDEPTH):0] count,
    output logic                    overflow,
    output logic                    collision
);
    localparam int AW = $clog2(pDEPTH);
    localparam logic [pTS_WIDTH-1:0] TS_ONE   = pTS_WIDTH'(1);
    localparam logic [AW:0]          CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          CNT_FULL = (AW+1)'(pDEPTH);

    logic [pTS_WIDTH-1:0]  r_ts;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic [63:0]           r_mem [pDEPTH];
    logic [63:0]           r_rd_data;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_collision;

    logic                  w_capture;
    logic                  w_pop;
    logic                  w_write;
    logic                  w_multi;
    logic [7:0]            w_rule;
    logic [55:0]           w_ts;
    logic [pTS_WIDTH-1:0]  w_stamp;
    logic [63:0]           w_entry;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_FULL);

    // clear wins over everything that would change FIFO contents this cycle
    assign w_capture = enable && (match != '0) && !clear;
    assign w_pop     = rd_en && !empty && !clear;
    assign w_write   = w_capture && (!full || w_pop);
    assign w_multi   = ((match & (match - pNUM_RULES'(1))) != '0);

    always_comb begin
        w_rule = '0;
        for (int i = pNUM_RULES-1; i >= 0; i--)
            if (match[i]) w_rule = 8'(i);
    end

`ifdef TRIGGER_TIMESTAMP_DELTA_EN
    logic [pTS_WIDTH-1:0] r_delta;

    // restarts at 1 so the next capture reports the full cycle gap
    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i)                r_delta <= '0;
        else if (clear)             r_delta <= '0;
        else if (w_write)           r_delta <= TS_ONE;
        else if (r_delta != '1)     r_delta <= r_delta + TS_ONE;
    end

    assign w_stamp = r_delta;
`else
    assign w_stamp = r_ts;
`endif

    always_comb begin
        w_ts = '0;
        w_ts[pTS_WIDTH-1:0] = w_stamp;
    end

    assign w_entry = {w_rule, w_ts};

    always_ff @(posedge trace_clk) begin
        if (w_write) r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i) begin
            r_ts        <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_collision <= 1'b0;
        end else if (clear) begin
            r_ts        <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_ts       <= r_ts + TS_ONE;
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + AW'(1);
            end
            if (w_write) r_wptr <= r_wptr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_capture && full && !w_pop) r_overflow  <= 1'b1;
            if (w_capture && w_multi)        r_collision <= 1'b1;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign collision = r_collision;

endmodule

// File: tb/tb_trigger_timestamp_fifo.sv
// Scoreboard bench for trigger_timestamp_fifo: queue-based reference model, directed corner cases plus random traffic.
module tb_trigger_timestamp_fifo;
    localparam int NR    = 8;
    localparam int TW    = 56;
    localparam int DEPTH = 16;
    localparam logic [63:0] TS_MAX = (64'd1 << TW) - 64'd1;

    logic          trace_clk = 1'b0;
    logic          reset_i   = 1'b1;
    logic          enable    = 1'b0;
    logic          clear     = 1'b0;
    logic [NR-1:0] match     = '0;
    logic          rd_en     = 1'b0;
    logic [63:0]   rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [4:0]    count;
    logic          overflow;
    logic          collision;

    trigger_timestamp_fifo #(.pNUM_RULES(NR), .pTS_WIDTH(TW), .pDEPTH(DEPTH)) dut (
        .trace_clk(trace_clk), .reset_i(reset_i), .enable(enable), .clear(clear),
        .match(match), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .count(count), .overflow(overflow), .collision(collision)
    );

    always #5 trace_clk = ~trace_clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] m_ts;
    logic [63:0] m_delta;
    bit          m_ovf;
    bit          m_col;
    bit          m_popped;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    function automatic int lowest(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        fifo_q.delete();
        m_ts = 0; m_delta = 0; m_ovf = 0; m_col = 0; m_popped = 0;
    endfunction

    // Called at a falling edge: drive one cycle of inputs, advance the model, then check state after the edge.
    task automatic step(input bit en, input bit clr, input logic [NR-1:0] m, input bit rd);
        bit wrote;
        logic [63:0] stamp;
        enable = en; clear = clr; match = m; rd_en = rd;
        wrote = 0;
        m_popped = 0;
        if (clr) begin
            model_reset();
        end else begin
            if (rd && fifo_q.size() != 0) begin
                exp_q.push_back(fifo_q.pop_front());
                m_popped = 1;
            end
            if (en && m != '0) begin
                if ($countones(m) > 1) m_col = 1;
`ifdef TRIGGER_TIMESTAMP_DELTA_EN
                stamp = m_delta;
`else
                stamp = m_ts;
`endif
                if (fifo_q.size() < DEPTH) begin
                    fifo_q.push_back({8'(lowest(m)), stamp[55:0]});
                    wrote = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            m_ts = (m_ts + 1) & TS_MAX;
            if (wrote)                m_delta = 1;
            else if (m_delta != TS_MAX) m_delta = m_delta + 1;
        end
        @(negedge trace_clk);
        check("count",     64'(count),     64'(fifo_q.size()));
        check("empty",     64'(empty),     64'(fifo_q.size() == 0));
        check("full",      64'(full),      64'(fifo_q.size() == DEPTH));
        check("overflow",  64'(overflow),  64'(m_ovf));
        check("collision", 64'(collision), 64'(m_col));
        check("rd_valid",  64'(rd_valid),  64'(m_popped));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0);
    endtask

    task automatic do_reset();
        enable = 0; clear = 0; match = '0; rd_en = 0;
        reset_i = 1'b1;
        #2;
        check("rst_rd_valid",  64'(rd_valid),  64'(0));
        check("rst_rd_data",   rd_data,        64'(0));
        check("rst_count",     64'(count),     64'(0));
        check("rst_empty",     64'(empty),     64'(1));
        check("rst_full",      64'(full),      64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));
        check("rst_collision", 64'(collision), 64'(0));
        model_reset();
        @(negedge trace_clk);
        reset_i = 1'b0;
    endtask

    function automatic logic [NR-1:0] rand_match();
        logic [NR-1:0] v;
        v = NR'($urandom);
        if (v == '0) v = NR'(1) << $urandom_range(0, NR-1);
        return v;
    endfunction

    // scoreboard monitor: every presented output must match the oldest expected pop
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge trace_clk);
            if (!reset_i && rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
    end

    initial begin
        @(negedge trace_clk);
        do_reset();

        // match[3] at counter 100, then pop
        while (m_ts != 100) step(0, 0, '0, 0);
        step(1, 0, 8'h08, 0);
        step(0, 0, '0, 1);
        check("pop_data_100", rd_data, 64'h03000000_00000064);
        check("pop_valid_100", 64'(rd_valid), 64'(1));
        idle(1);
        check("pop_valid_drop", 64'(rd_valid), 64'(0));

        // collision: two rules in one cycle
        step(0, 1, '0, 0);
        step(1, 0, 8'b00010100, 0);
        check("col_flag", 64'(collision), 64'(1));
        check("col_count", 64'(count), 64'(1));
        step(0, 0, '0, 1);
        check("col_rule", 64'(rd_data[63:56]), 64'(2));

        // 17 matches with no pops
        step(0, 1, '0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, rand_match(), 0);
        check("ovf_full", 64'(full), 64'(1));
        check("ovf_count", 64'(count), 64'(16));
        check("ovf_flag", 64'(overflow), 64'(1));
        for (int i = 0; i < 16; i++) step(0, 0, '0, 1);
        idle(2);

        // full FIFO with simultaneous write and pop
        step(0, 1, '0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, rand_match(), 0);
        step(1, 0, 8'h80, 1);
        check("wp_count", 64'(count), 64'(16));
        check("wp_ovf", 64'(overflow), 64'(0));
        for (int i = 0; i < 16; i++) step(0, 0, '0, 1);
        check("wp_last_rule", 64'(rd_data[63:56]), 64'(7));
        idle(2);

        // clear together with match and rd_en
        for (int i = 0; i < 3; i++) step(1, 0, rand_match(), 0);
        step(1, 1, 8'h01, 1);
        check("clr_empty", 64'(empty), 64'(1));
        check("clr_count", 64'(count), 64'(0));
        idle(2);

        // random traffic: fill-heavy phase then drain-heavy phase
        for (int i = 0; i < 400; i++) begin
            bit rd;
            rd = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                 ($urandom_range(0, 2) == 0) ? '0 : rand_match(), rd);
        end
        idle(2);

        // reset mid-operation: entries lost, counter restarts
        for (int i = 0; i < 4; i++) step(1, 0, rand_match(), 0);
        idle(1);
        do_reset();
        check("mid_rst_empty", 64'(empty), 64'(1));
        idle(5);
        step(1, 0, 8'h20, 0);
        step(0, 0, '0, 1);
        check("mid_rst_data", rd_data, 64'h05000000_00000005);
        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end
endmodule
